gpio_ctrl: RTL and testbench

Parametrised GPIO controller for the peripheral bus. It supersedes the fixed 16-bit LED/switch block.
- WIDTH pins, per-pin direction control.
- Atomic set/clear/toggle of the output register; bus byte enables honoured.
- Two-flop input synchronisers and per-pin rising/falling edge interrupts with sticky W1C status, combined into one irq_o line.

---
 rtl/gpio_ctrl_pkg.sv | 26 ++
 rtl/gpio_sync_edge.sv | 32 +++
 rtl/gpio_ctrl.sv | 129 ++++++++++++
 tb/tb_gpio_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared register offsets and bus helpers for the GPIO controller.
// Offsets are byte addresses; address bits [1:0] are never decoded.
package gpio_ctrl_pkg;

    localparam logic [7:0] ADDR_OUT      = 8'h00;
    localparam logic [7:0] ADDR_IN       = 8'h04;
    localparam logic [7:0] ADDR_DIR      = 8'h08;
    localparam logic [7:0] ADDR_OUT_SET  = 8'h0C;
    localparam logic [7:0] ADDR_OUT_CLR  = 8'h10;
    localparam logic [7:0] ADDR_OUT_TGL  = 8'h14;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h18;
    localparam logic [7:0] ADDR_IRQ_RISE = 8'h1C;
    localparam logic [7:0] ADDR_IRQ_FALL = 8'h20;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h24;
    localparam logic [7:0] ADDR_INFO     = 8'h28;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain plus one history flop; flags rising/falling
// transitions between the synchronised value and its previous sample.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] gpio_raw,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]                  prev_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], gpio_raw};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync = stage_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: bus register file, atomic output updates,
// synchronised inputs and sticky edge interrupts combined onto irq_o.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [31:0]      bus_addr,
    input  logic [3:0]       bus_be,
    input  logic [31:0]      bus_wdata,
    output logic             bus_ack,
    output logic             bus_resp,
    output logic [31:0]      bus_rdata,
    input  logic [WIDTH-1:0] gpio_bi,
    output logic [WIDTH-1:0] gpio_bo,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    localparam logic [5:0] INFO_WIDTH = 6'(WIDTH);

    logic [WIDTH-1:0] out_q, dir_q, en_q, rise_en_q, fall_en_q, stat_q;
    logic [WIDTH-1:0] out_d, dir_d, en_d, rise_en_d, fall_en_d, stat_d;
    logic [WIDTH-1:0] in_sync, pin_rise, pin_fall, ev;
    logic [WIDTH-1:0] m, d;
    logic [31:0]      wmask, wd_full, rd_data, rdata_q;
    logic [7:0]       reg_addr;
    logic             wr, rd, resp_q;
    logic             unused_bits;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .gpio_raw (gpio_bi),
        .sync     (in_sync),
        .rise     (pin_rise),
        .fall     (pin_fall)
    );

    assign reg_addr = {bus_addr[7:2], 2'b00};
    assign wr       = bus_req & bus_we;
    assign rd       = bus_req & ~bus_we;
    assign wmask    = be_to_mask(bus_be);
    assign wd_full  = bus_wdata & wmask;
    assign m        = wmask[WIDTH-1:0];
    assign d        = wd_full[WIDTH-1:0];
    assign ev       = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

    assign unused_bits = ^{bus_addr[31:8], bus_addr[1:0], wmask, wd_full};

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        en_d      = en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        // OR-ing ev after the W1C mask makes a same-cycle event win over a clear
        stat_d    = stat_q | ev;
        if (wr) begin
            case (reg_addr)
                ADDR_OUT:      out_d     = (out_q & ~m) | d;
                ADDR_DIR:      dir_d     = (dir_q & ~m) | d;
                ADDR_OUT_SET:  out_d     = out_q | d;
                ADDR_OUT_CLR:  out_d     = out_q & ~d;
                ADDR_OUT_TGL:  out_d     = out_q ^ d;
                ADDR_IRQ_EN:   en_d      = (en_q & ~m) | d;
                ADDR_IRQ_RISE: rise_en_d = (rise_en_q & ~m) | d;
                ADDR_IRQ_FALL: fall_en_d = (fall_en_q & ~m) | d;
                ADDR_IRQ_STAT: stat_d    = (stat_q & ~d) | ev;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr)
            ADDR_OUT:      rd_data = 32'(out_q);
            ADDR_IN:       rd_data = 32'(in_sync);
            ADDR_DIR:      rd_data = 32'(dir_q);
            ADDR_IRQ_EN:   rd_data = 32'(en_q);
            ADDR_IRQ_RISE: rd_data = 32'(rise_en_q);
            ADDR_IRQ_FALL: rd_data = 32'(fall_en_q);
            ADDR_IRQ_STAT: rd_data = 32'(stat_q);
            ADDR_INFO:     rd_data = {26'd0, INFO_WIDTH};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q     <= '0;
            dir_q     <= '0;
            en_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            en_q      <= en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            resp_q    <= rd;
            if (rd) begin
                rdata_q <= rd_data;
            end
        end
    end

    assign bus_ack   = bus_req;
    assign bus_resp  = resp_q;
    assign bus_rdata = rdata_q;
    assign gpio_bo   = out_q;
    assign gpio_oe   = dir_q;
    assign irq_o     = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed register/IRQ scenarios plus
// randomized bus and pin traffic against a transaction-level model.
module tb_gpio_ctrl;

    localparam int W = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          bus_req, bus_we;
    logic [31:0]   bus_addr, bus_wdata, bus_rdata;
    logic [3:0]    bus_be;
    logic          bus_ack, bus_resp, irq_o;
    logic [W-1:0]  gpio_bi, gpio_bo, gpio_oe;

    always #5 clk_i = ~clk_i;

    gpio_ctrl #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_resp  (bus_resp),
        .bus_rdata (bus_rdata),
        .gpio_bi   (gpio_bi),
        .gpio_bo   (gpio_bo),
        .gpio_oe   (gpio_oe),
        .irq_o     (irq_o)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: register values plus the history of pin samples taken
    // at each clock edge (pin_hist[0] = newest). IN shows the sample from one
    // edge earlier; edges compare IN against the sample one edge older still.
    logic [W-1:0]  m_out, m_dir, m_en, m_rise, m_fall, m_stat;
    logic [W-1:0]  pin_hist[$];
    logic          m_resp;
    logic [31:0]   m_rdata;

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
        pin_hist = '{16'h0, 16'h0, 16'h0};
        m_resp = 1'b0;
        m_rdata = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00:   return {16'h0, m_out};
            8'h04:   return {16'h0, pin_hist[1]};
            8'h08:   return {16'h0, m_dir};
            8'h18:   return {16'h0, m_en};
            8'h1C:   return {16'h0, m_rise};
            8'h20:   return {16'h0, m_fall};
            8'h24:   return {16'h0, m_stat};
            8'h28:   return W;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic req, input logic we, input logic [7:0] a,
                              input logic [3:0] be, input logic [31:0] wd, input logic [W-1:0] pins);
        logic [W-1:0] bm, dd, rise, fall, ev, new_stat;
        for (int i = 0; i < 2; i++) bm[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        dd   = wd[W-1:0] & bm;
        rise = pin_hist[1] & ~pin_hist[2];
        fall = ~pin_hist[1] & pin_hist[2];
        ev   = (rise & m_rise) | (fall & m_fall);
        m_resp = req && !we;
        if (m_resp) m_rdata = m_read(a);
        new_stat = m_stat | ev;
        if (req && we) begin
            case (a & 8'hFC)
                8'h00: m_out  = (m_out & ~bm) | dd;
                8'h08: m_dir  = (m_dir & ~bm) | dd;
                8'h0C: m_out  = m_out | dd;
                8'h10: m_out  = m_out & ~dd;
                8'h14: m_out  = m_out ^ dd;
                8'h18: m_en   = (m_en & ~bm) | dd;
                8'h1C: m_rise = (m_rise & ~bm) | dd;
                8'h20: m_fall = (m_fall & ~bm) | dd;
                8'h24: new_stat = (m_stat & ~dd) | ev;
                default: ;
            endcase
        end
        m_stat = new_stat;
        pin_hist.push_front(pins);
        pin_hist.delete(3);
    endtask

    task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
        bus_req = req; bus_we = we; bus_addr = addr; bus_be = be; bus_wdata = wd;
        #1;
        check("ack", bus_ack, req);
        @(posedge clk_i);
        model_edge(req, we, addr[7:0], be, wd, gpio_bi);
        #1;
        check("resp", bus_resp, m_resp);
        check("rdata", bus_rdata, m_rdata);
        check("gpio_bo", gpio_bo, m_out);
        check("gpio_oe", gpio_oe, m_dir);
        check("irq_o", irq_o, |(m_stat & m_en));
        bus_req = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cyc(1'b1, 1'b0, addr, 4'h0, 32'h0);
        check(tag, bus_rdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        cyc(1'b1, 1'b1, addr, be, wd);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    logic [7:0] addr_pool[14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                  8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h40, 8'hFC};

    initial begin
        logic [31:0] a32;
        logic [W-1:0] flip;

        rst_i = 1'b0;
        gpio_bi = '1;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_be = '0; bus_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_bo", gpio_bo, 0);
        check("rst_oe", gpio_oe, 0);
        check("rst_irq", irq_o, 0);
        check("rst_resp", bus_resp, 0);
        check("rst_rdata", bus_rdata, 0);
        rst_i = 1'b1;

        rd("rst_out", 32'h00, 0);
        rd("rst_dir", 32'h08, 0);
        rd("rst_stat", 32'h24, 0);

        wr(32'h00, 4'b0010, 32'h0000A5C3);  check("be_out", gpio_bo, 16'hA500);
        wr(32'h0C, 4'b0001, 32'h0000000F);  check("set", gpio_bo, 16'hA50F);
        wr(32'h10, 4'b1111, 32'h00000100);  check("clr", gpio_bo, 16'hA40F);
        wr(32'h14, 4'b1111, 32'h0000FFFF);  check("tgl", gpio_bo, 16'h5BF0);
        rd("out_rb", 32'h00, 16'h5BF0);
        wr(32'h00, 4'b1111, 32'hFFFF_FFFF);
        rd("hi_bits_zero", 32'h01, 32'h0000FFFF);

        gpio_bi = '0;
        idle(4);
        wr(32'h08, 4'hF, 32'h0);
        gpio_bi = 16'h0008;
        rd("in_edge_k", 32'h04, 0);
        rd("in_edge_k1", 32'h04, 0);
        rd("in_edge_k2", 32'h04, 16'h0008);
        rd("info", 32'h28, 16);

        gpio_bi = '0;
        idle(4);
        wr(32'h18, 4'hF, 32'h0008);
        wr(32'h1C, 4'hF, 32'h0008);
        gpio_bi = 16'h0008;
        idle(4);
        check("rise_irq", irq_o, 1);
        rd("rise_stat", 32'h24, 16'h0008);
        wr(32'h24, 4'hF, 32'h0008);
        check("w1c_irq", irq_o, 0);
        gpio_bi = '0;
        idle(4);
        rd("fall_no_ev", 32'h24, 0);

        wr(32'h20, 4'hF, 32'h0001);
        gpio_bi = 16'h0001; idle(4);
        gpio_bi = 16'h0000; idle(4);
        rd("fall_stat", 32'h24, 16'h0001);
        gpio_bi = 16'h0001; idle(4);
        gpio_bi = 16'h0000;
        idle(2);
        wr(32'h24, 4'hF, 32'h0001);
        rd("set_wins", 32'h24, 16'h0001);
        wr(32'h24, 4'hF, 32'h0001);
        rd("cleared", 32'h24, 0);

        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 7) == 0);
            gpio_bi = gpio_bi ^ flip;
            a32 = $urandom();
            a32[7:0] = addr_pool[$urandom_range(0, 13)] | 8'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a32,
                4'($urandom_range(0, 15)), $urandom());
        end

        gpio_bi = '0; idle(4);
        wr(32'h1C, 4'hF, 32'hFFFF);
        wr(32'h18, 4'hF, 32'hFFFF);
        wr(32'h00, 4'hF, 32'h1234);
        wr(32'h08, 4'hF, 32'h00FF);
        gpio_bi = '1; idle(4);
        check("pre_rst_irq", irq_o, 1);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h0; bus_be = 4'h0;
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_irq", irq_o, 0);
        check("arst_bo", gpio_bo, 0);
        check("arst_oe", gpio_oe, 0);
        check("arst_resp", bus_resp, 0);
        check("arst_rdata", bus_rdata, 0);
        @(posedge clk_i);
        #1;
        check("arst_resp_held", bus_resp, 0);
        bus_req = 1'b0;
        model_reset();
        rst_i = 1'b1;
        rd("post_rst_out", 32'h00, 0);
        rd("post_rst_stat", 32'h24, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
